// File: rtl/ast_width_downsizer_pkg.sv
// ---------------------------------------------------------------------------
// ast_width_downsizer_pkg
//   Shared definitions for the Avalon-ST width converter pair (128->64
//   downsizer and 64->128 upsizer). Holds the default widths, the derived
//   empty-field widths, field typedefs and the downsizer state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package ast_width_downsizer_pkg;

  // Returns ceil(log2(v)), but never less than 1, so a field always has a bit.
  function automatic int clog2_min1(input int v);
    return ($clog2(v) > 1) ? $clog2(v) : 1;
  endfunction

  localparam int DEF_DATA_IN_W   = 128;
  localparam int DEF_DATA_OUT_W  = 64;
  localparam int DEF_CHANNEL_W   = 10;
  localparam int DEF_EMPTY_IN_W  = clog2_min1(DEF_DATA_IN_W / 8);
  localparam int DEF_EMPTY_OUT_W = clog2_min1(DEF_DATA_OUT_W / 8);

  typedef logic [DEF_CHANNEL_W-1:0]   channel_t;
  typedef logic [DEF_EMPTY_IN_W-1:0]  empty_in_t;
  typedef logic [DEF_EMPTY_OUT_W-1:0] empty_out_t;

  // EMPTY: holding register free. SENDING: a wide beat is being emitted.
  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_SENDING = 1'b1
  } dsz_state_e;

endpackage : ast_width_downsizer_pkg

// File: rtl/ast_width_downsizer.sv
// ---------------------------------------------------------------------------
// ast_width_downsizer
//   Avalon-ST width downconverter. Each accepted wide beat is held in one
//   register and re-emitted as DATA_IN_W/DATA_OUT_W narrow pieces, low-order
//   piece first. Packet framing (sop/eop), channel and empty are preserved;
//   an eop beat with a large empty emits only the pieces that carry data.
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   ast_*_i (wide side)    data/sop/eop/valid/empty/channel in, ast_ready_o out
//   ast_*_o (narrow side)  data/sop/eop/valid/empty/channel out, ast_ready_i in
// ---------------------------------------------------------------------------
module ast_width_downsizer
  import ast_width_downsizer_pkg::*;
#(
  parameter int DATA_IN_W   = DEF_DATA_IN_W,
  parameter int DATA_OUT_W  = DEF_DATA_OUT_W,
  parameter int CHANNEL_W   = DEF_CHANNEL_W,
  parameter int EMPTY_IN_W  = clog2_min1(DATA_IN_W / 8),
  parameter int EMPTY_OUT_W = clog2_min1(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i
);

  localparam int R        = DATA_IN_W / DATA_OUT_W;
  localparam int B        = DATA_OUT_W / 8;
  localparam int BYTES_IN = DATA_IN_W / 8;
  localparam int IDX_W    = clog2_min1(R);

  if ((DATA_IN_W % DATA_OUT_W) != 0) begin : g_err_ratio
    $error("ast_width_downsizer: DATA_IN_W must be a multiple of DATA_OUT_W");
  end
  if ((DATA_OUT_W % 8) != 0) begin : g_err_bytes
    $error("ast_width_downsizer: DATA_OUT_W must be a multiple of 8");
  end

  dsz_state_e            state_q, state_d;
  logic [DATA_IN_W-1:0]  buf_data_q, buf_data_d;
  logic                  buf_sop_q, buf_sop_d;
  logic                  buf_eop_q, buf_eop_d;
  logic [EMPTY_IN_W-1:0] buf_empty_q, buf_empty_d;
  logic [CHANNEL_W-1:0]  buf_channel_q, buf_channel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      last_idx_q, last_idx_d;

  logic                  buf_valid;
  logic                  last_piece;
  logic                  accept;
  logic                  advance;
  logic [IDX_W-1:0]      accept_last_idx;

  assign buf_valid  = (state_q == ST_SENDING);
  assign last_piece = (idx_q == last_idx_q);

  // The holding register can take a new beat when it is free, or when its
  // final piece leaves in this very cycle; that second case is what keeps
  // consecutive wide beats bubble-free. Held low throughout reset.
  assign ast_ready_o = ~rst_i & (~buf_valid | (last_piece & ast_ready_i));
  assign accept      = ast_valid_i & ast_ready_o;
  assign advance     = buf_valid & ast_ready_i;

  // Index of the last piece that carries data. Whole empty pieces at the top
  // of an eop beat are never emitted; empty is ignored on non-eop beats.
  always_comb begin
    accept_last_idx = IDX_W'(R - 1);
    if (ast_endofpacket_i) begin
      accept_last_idx = IDX_W'(R - 1 - (int'(ast_empty_i) / B));
    end
  end

  // Next-state: step through the pieces of the held beat, then either reload
  // from the input (same-cycle accept) or fall back to EMPTY.
  always_comb begin
    state_d       = state_q;
    buf_data_d    = buf_data_q;
    buf_sop_d     = buf_sop_q;
    buf_eop_d     = buf_eop_q;
    buf_empty_d   = buf_empty_q;
    buf_channel_d = buf_channel_q;
    idx_d         = idx_q;
    last_idx_d    = last_idx_q;

    if (advance) begin
      if (!last_piece) begin
        idx_d = idx_q + IDX_W'(1);
      end else begin
        state_d = ST_EMPTY;
      end
    end

    if (accept) begin
      state_d       = ST_SENDING;
      buf_data_d    = ast_data_i;
      buf_sop_d     = ast_startofpacket_i;
      buf_eop_d     = ast_endofpacket_i;
      buf_empty_d   = ast_empty_i;
      buf_channel_d = ast_channel_i;
      idx_d         = '0;
      last_idx_d    = accept_last_idx;
    end
  end

  // State and holding register. Reset discards any half-sent beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_EMPTY;
      buf_data_q    <= '0;
      buf_sop_q     <= 1'b0;
      buf_eop_q     <= 1'b0;
      buf_empty_q   <= '0;
      buf_channel_q <= '0;
      idx_q         <= '0;
      last_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      buf_data_q    <= buf_data_d;
      buf_sop_q     <= buf_sop_d;
      buf_eop_q     <= buf_eop_d;
      buf_empty_q   <= buf_empty_d;
      buf_channel_q <= buf_channel_d;
      idx_q         <= idx_d;
      last_idx_q    <= last_idx_d;
    end
  end

  // Narrow side is decoded purely from registers. Framing flags and empty
  // are qualified by buf_valid so they never show up on an idle bus.
  always_comb begin
    ast_valid_o         = buf_valid;
    ast_data_o          = buf_data_q[int'(idx_q) * DATA_OUT_W +: DATA_OUT_W];
    ast_startofpacket_o = buf_valid & buf_sop_q & (idx_q == '0);
    ast_endofpacket_o   = buf_valid & buf_eop_q & last_piece;
    ast_empty_o         = '0;
    if (ast_endofpacket_o) begin
      ast_empty_o = EMPTY_OUT_W'(int'(buf_empty_q) % B);
    end
    ast_channel_o       = buf_channel_q;
  end

  // An eop beat whose empty covers the whole beat has no data to emit.
  a_legal_empty : assert property (
    @(posedge clk_i) disable iff (rst_i)
      (accept && ast_endofpacket_i) |-> (int'(ast_empty_i) < BYTES_IN)
  ) else $error("ast_width_downsizer: eop beat with empty >= bytes per beat");

endmodule : ast_width_downsizer

// File: tb/tb_ast_width_downsizer.sv
// Self-checking bench for ast_width_downsizer at default widths
// (128 -> 64, channel 10). Pieces leaving the DUT are collected by a monitor
// and compared in order against hand-written or modelled expected pieces.
module tb_ast_width_downsizer;

   typedef struct packed {
      logic [63:0] data;
      logic        sop;
      logic        eop;
      logic [2:0]  empty;
      logic [9:0]  ch;
   } piece_t;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic [127:0] ast_data_i;
   logic         ast_startofpacket_i;
   logic         ast_endofpacket_i;
   logic         ast_valid_i;
   logic [3:0]   ast_empty_i;
   logic [9:0]   ast_channel_i;
   logic         ast_ready_o;
   logic [63:0]  ast_data_o;
   logic         ast_startofpacket_o;
   logic         ast_endofpacket_o;
   logic         ast_valid_o;
   logic [2:0]   ast_empty_o;
   logic [9:0]   ast_channel_o;
   logic         ast_ready_i;

   logic         fixedReady;
   logic         randomReady;
   logic         rndReady;
   int           stallLeft;

   int           numChecks;
   int           numFails;
   int           cycleCount;

   piece_t       expectedQ[$];
   piece_t       actualQ[$];
   int           actualCyc[$];
   logic         readyLog[$];

   logic         prevStall;
   piece_t       prevPiece;

   assign ast_ready_i = randomReady ? rndReady : fixedReady;

   always #5 clk_i = ~clk_i;

   ast_width_downsizer dut (
      .clk_i               (clk_i),
      .rst_i               (rst_i),
      .ast_data_i          (ast_data_i),
      .ast_startofpacket_i (ast_startofpacket_i),
      .ast_endofpacket_i   (ast_endofpacket_i),
      .ast_valid_i         (ast_valid_i),
      .ast_empty_i         (ast_empty_i),
      .ast_channel_i       (ast_channel_i),
      .ast_ready_o         (ast_ready_o),
      .ast_data_o          (ast_data_o),
      .ast_startofpacket_o (ast_startofpacket_o),
      .ast_endofpacket_o   (ast_endofpacket_o),
      .ast_valid_o         (ast_valid_o),
      .ast_empty_o         (ast_empty_o),
      .ast_channel_o       (ast_channel_o),
      .ast_ready_i         (ast_ready_i)
   );

   // Free-running cycle counter used to timestamp captured pieces.
   always @(posedge clk_i) cycleCount <= cycleCount + 1;

   // Random downstream ready: runs of 1..10 stall cycles mixed with ready.
   always @(posedge clk_i) begin
      #1;
      if (stallLeft > 0) begin
         rndReady  = 1'b0;
         stallLeft = stallLeft - 1;
      end else begin
         rndReady = 1'b1;
         if ($urandom_range(0, 2) == 0) stallLeft = int'($urandom_range(1, 10));
      end
   end

   // Single comparison point: counts every check, reports any mismatch.
   task automatic checkOutput(input string tag, input logic [127:0] actual,
                              input logic [127:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
      end
   endtask

   // Monitor, mid-cycle: captures each piece that transfers at the next
   // rising edge, and checks that a stalled piece is held unchanged.
   always @(negedge clk_i) begin
      piece_t cur;
      cur = '{data: ast_data_o, sop: ast_startofpacket_o, eop: ast_endofpacket_o,
              empty: ast_empty_o, ch: ast_channel_o};
      if (rst_i) begin
         prevStall = 1'b0;
      end else begin
         if (prevStall) checkOutput("hold during stall", cur, prevPiece);
         if (ast_valid_o && ast_ready_i) begin
            actualQ.push_back(cur);
            actualCyc.push_back(cycleCount);
         end
         prevStall = ast_valid_o && !ast_ready_i;
         prevPiece = cur;
      end
   end

   // Drives one wide beat and holds it until accepted (bounded wait).
   // Called just after a rising edge; returns just after the accepting edge.
   task automatic applyStimulus(input logic [127:0] data, input logic sop,
                                input logic eop, input logic [3:0] empty,
                                input logic [9:0] ch, input logic logReady);
      logic accepted;
      ast_data_i          = data;
      ast_startofpacket_i = sop;
      ast_endofpacket_i   = eop;
      ast_empty_i         = empty;
      ast_channel_i       = ch;
      ast_valid_i         = 1'b1;
      accepted            = 1'b0;
      for (int c = 0; c < 200 && !accepted; c++) begin
         @(negedge clk_i);
         if (logReady) readyLog.push_back(ast_ready_o);
         accepted = ast_ready_o;
         @(posedge clk_i);
         #1;
      end
      if (!accepted) checkOutput("accept timeout", 128'(accepted), 128'd1);
   endtask

   // Deasserts valid and scrambles the other inputs, which must be ignored.
   task automatic idleInputs();
      ast_valid_i         = 1'b0;
      ast_data_i          = {$urandom, $urandom, $urandom, $urandom};
      ast_startofpacket_i = 1'($urandom);
      ast_endofpacket_i   = 1'($urandom);
      ast_empty_i         = 4'($urandom);
      ast_channel_i       = 10'($urandom);
   endtask

   // Expected pieces of one wide beat, straight from the piece-count rule.
   task automatic pushModel(input logic [127:0] data, input logic sop,
                            input logic eop, input logic [3:0] empty,
                            input logic [9:0] ch);
      int n;
      piece_t p;
      n = eop ? 2 - int'(empty) / 8 : 2;
      for (int k = 0; k < n; k++) begin
         p.data  = data[64*k +: 64];
         p.sop   = sop && (k == 0);
         p.eop   = eop && (k == n - 1);
         p.empty = (eop && (k == n - 1)) ? 3'(int'(empty) % 8) : 3'd0;
         p.ch    = ch;
         expectedQ.push_back(p);
      end
   endtask

   task automatic waitDrain(input int bound);
      for (int c = 0; c < bound && actualQ.size() < expectedQ.size(); c++) begin
         @(posedge clk_i);
         #1;
      end
      if (actualQ.size() < expectedQ.size())
         checkOutput("drain timeout", 128'(actualQ.size()), 128'(expectedQ.size()));
      repeat (3) @(posedge clk_i);
      #1;
   endtask

   task automatic compareQueues(input string tag);
      checkOutput($sformatf("%s piece count", tag), 128'(actualQ.size()),
                  128'(expectedQ.size()));
      for (int i = 0; i < expectedQ.size() && i < actualQ.size(); i++)
         checkOutput($sformatf("%s piece %0d", tag, i), actualQ[i], expectedQ[i]);
      expectedQ.delete();
      actualQ.delete();
      actualCyc.delete();
   endtask

   initial begin
      numChecks   = 0;
      numFails    = 0;
      cycleCount  = 0;
      stallLeft   = 0;
      rndReady    = 1'b1;
      prevStall   = 1'b0;
      prevPiece   = '0;
      rst_i       = 1'b1;
      fixedReady  = 1'b1;
      randomReady = 1'b0;
      idleInputs();

      // ---- Reset values ----
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      checkOutput("reset valid_o", 128'(ast_valid_o), 128'd0);
      checkOutput("reset ready_o", 128'(ast_ready_o), 128'd0);
      checkOutput("reset data_o", 128'(ast_data_o), 128'd0);
      checkOutput("reset sop/eop", 128'({ast_startofpacket_o, ast_endofpacket_o}), 128'd0);
      checkOutput("reset empty/channel", 128'({ast_empty_o, ast_channel_o}), 128'd0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("ready after release", 128'(ast_ready_o), 128'd1);
      @(posedge clk_i);
      #1;

      // ---- Reset mid-packet drops the held beat ----
      fixedReady = 1'b0;
      applyStimulus({64'hDEAD_BEEF_0000_0001, 64'hCAFE_F00D_0000_0002}, 1'b1, 1'b0,
                    4'd0, 10'h155, 1'b0);
      idleInputs();
      @(negedge clk_i);
      checkOutput("held piece valid", 128'(ast_valid_o), 128'd1);
      #1 rst_i = 1'b1;
      #1;
      checkOutput("mid-packet reset valid_o", 128'(ast_valid_o), 128'd0);
      checkOutput("mid-packet reset ready_o", 128'(ast_ready_o), 128'd0);
      @(negedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      fixedReady = 1'b1;
      repeat (5) @(posedge clk_i);
      #1;
      checkOutput("no stale pieces", 128'(actualQ.size()), 128'd0);
      @(negedge clk_i);
      checkOutput("ready after mid-packet reset", 128'(ast_ready_o), 128'd1);
      @(posedge clk_i);
      #1;

      // ---- Single-beat packet, full width ----
      expectedQ.push_back('{data: 64'h2222_2222_2222_2222, sop: 1'b1, eop: 1'b0,
                            empty: 3'd0, ch: 10'h003});
      expectedQ.push_back('{data: 64'h1111_1111_1111_1111, sop: 1'b0, eop: 1'b1,
                            empty: 3'd0, ch: 10'h003});
      applyStimulus({64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222}, 1'b1, 1'b1,
                    4'd0, 10'h003, 1'b0);
      idleInputs();
      waitDrain(50);
      compareQueues("single beat");

      // ---- Short tails: empty 11 -> one piece, empty 5 -> two pieces ----
      expectedQ.push_back('{data: 64'h0123_4567_89AB_CDEF, sop: 1'b1, eop: 1'b1,
                            empty: 3'd3, ch: 10'h07E});
      expectedQ.push_back('{data: 64'h5555_6666_7777_8888, sop: 1'b1, eop: 1'b0,
                            empty: 3'd0, ch: 10'h101});
      expectedQ.push_back('{data: 64'h0000_00AB_CDEF_0123, sop: 1'b0, eop: 1'b1,
                            empty: 3'd5, ch: 10'h101});
      applyStimulus({64'hAAAA_AAAA_AAAA_AAAA, 64'h0123_4567_89AB_CDEF}, 1'b1, 1'b1,
                    4'd11, 10'h07E, 1'b0);
      applyStimulus({64'h0000_00AB_CDEF_0123, 64'h5555_6666_7777_8888}, 1'b1, 1'b1,
                    4'd5, 10'h101, 1'b0);
      idleInputs();
      waitDrain(50);
      compareQueues("short tail");

      // ---- Streaming 10-beat packet, ready held high ----
      readyLog.delete();
      for (int b = 0; b < 10; b++) begin
         logic [127:0] d;
         d = {32'hA5A5_0000 + 32'(b), 32'h1111_0000 + 32'(b),
              32'h5A5A_0000 + 32'(b), 32'h2222_0000 + 32'(b)};
         pushModel(d, b == 0, b == 9, 4'd0, 10'h2A5);
         applyStimulus(d, b == 0, b == 9, 4'd0, 10'h2A5, 1'b1);
      end
      idleInputs();
      waitDrain(100);
      checkOutput("stream ready_o samples", 128'(readyLog.size()), 128'd19);
      for (int i = 0; i < readyLog.size(); i++)
         checkOutput($sformatf("stream ready_o %0d", i), 128'(readyLog[i]),
                     128'(i % 2 == 0));
      if (actualCyc.size() == 20)
         checkOutput("stream back-to-back span", 128'(actualCyc[19] - actualCyc[0]),
                     128'd19);
      else
         checkOutput("stream capture count", 128'(actualCyc.size()), 128'd20);
      compareQueues("stream");

      // ---- Random backpressure, several packets ----
      randomReady = 1'b1;
      for (int pk = 0; pk < 4; pk++) begin
         int          len;
         logic [9:0]  ch;
         len = (pk == 1) ? 1 : int'($urandom_range(2, 5));
         ch  = 10'($urandom);
         for (int b = 0; b < len; b++) begin
            logic [127:0] d;
            logic [3:0]   e;
            d = {$urandom, $urandom, $urandom, $urandom};
            e = (b == len - 1) ? 4'($urandom_range(0, 15)) : 4'($urandom);
            pushModel(d, b == 0, b == len - 1, e, ch);
            applyStimulus(d, b == 0, b == len - 1, e, ch, 1'b0);
            if ($urandom_range(0, 3) == 0) begin
               idleInputs();
               repeat ($urandom_range(1, 3)) @(posedge clk_i);
               #1;
            end
         end
      end
      idleInputs();
      waitDrain(3000);
      randomReady = 1'b0;
      compareQueues("backpressure");

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

   // Absolute guard so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule : tb_ast_width_downsizer
